// File: rtl/mem_arbiter_if.sv
// Requester handshakes and RAM control strobes of the two-port memory arbiter.
// The shared RAM data bus is a plain inout on the arbiter itself.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
);
  logic                     i_A_REQ;
  logic                     i_A_WE;
  logic [ADDRESS_WIDTH-1:0] i_A_ADDR;
  logic [DATA_WIDTH-1:0]    i_A_DATA;
  logic                     o_A_ACK;
  logic [DATA_WIDTH-1:0]    o_A_DATA;

  logic                     i_B_REQ;
  logic                     i_B_WE;
  logic [ADDRESS_WIDTH-1:0] i_B_ADDR;
  logic [DATA_WIDTH-1:0]    i_B_DATA;
  logic                     o_B_ACK;
  logic [DATA_WIDTH-1:0]    o_B_DATA;

  logic [ADDRESS_WIDTH-1:0] o_MAR_DATA;
  logic                     o_BUS_READ;
  logic                     o_BUS_WRITE_n;
  logic                     o_BUSY;

  // requesters and RAM side
  modport master (
    output i_A_REQ, i_A_WE, i_A_ADDR, i_A_DATA,
    output i_B_REQ, i_B_WE, i_B_ADDR, i_B_DATA,
    input  o_A_ACK, o_A_DATA, o_B_ACK, o_B_DATA,
    input  o_MAR_DATA, o_BUS_READ, o_BUS_WRITE_n, o_BUSY
  );

  // arbiter
  modport slave (
    input  i_A_REQ, i_A_WE, i_A_ADDR, i_A_DATA,
    input  i_B_REQ, i_B_WE, i_B_ADDR, i_B_DATA,
    output o_A_ACK, o_A_DATA, o_B_ACK, o_B_DATA,
    output o_MAR_DATA, o_BUS_READ, o_BUS_WRITE_n, o_BUSY
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM on a shared
// tristate data bus. Every transaction walks IDLE -> SETUP -> ACCESS -> ACK.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting; picks a winner and latches its WE/ADDR/DATA
//   SETUP  | address presented on MAR, bus idle
//   ACCESS | read: RAM output enabled, bus captured at closing edge
//          | write: bus driven, RAM capture strobe high
//   ACK    | one-cycle ack to the granted port, last-grant pointer updated
module mem_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                  i_CLOCK,
  input  logic                  i_RESET,
  mem_arbiter_if.slave          arb_if,
  inout  wire  [DATA_WIDTH-1:0] BUS
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     gnt_b_q, gnt_b_d;
  logic                     last_b_q, last_b_d;
  logic [DATA_WIDTH-1:0]    a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0]    b_rdata_q, b_rdata_d;
  logic                     a_ack_q, a_ack_d;
  logic                     b_ack_q, b_ack_d;
  logic                     bus_read_q, bus_read_d;
  logic                     bus_wr_n_q, bus_wr_n_d;
  logic                     bus_drive_q, bus_drive_d;
  logic                     busy_q, busy_d;
  logic                     pick_b;

  // Next-state and next-output computation; outputs are decided one state ahead
  // so that every strobe comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    gnt_b_d     = gnt_b_q;
    last_b_d    = last_b_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    bus_read_d  = 1'b0;
    bus_wr_n_d  = 1'b1;
    bus_drive_d = 1'b0;
    busy_d      = 1'b1;
    // B wins when it is alone, or on a tie when A was granted last.
    pick_b      = arb_if.i_B_REQ && (!arb_if.i_A_REQ || !last_b_q);

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (arb_if.i_A_REQ || arb_if.i_B_REQ) begin
          gnt_b_d = pick_b;
          we_d    = pick_b ? arb_if.i_B_WE   : arb_if.i_A_WE;
          addr_d  = pick_b ? arb_if.i_B_ADDR : arb_if.i_A_ADDR;
          wdata_d = pick_b ? arb_if.i_B_DATA : arb_if.i_A_DATA;
          state_d = S_SETUP;
          busy_d  = 1'b1;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        if (we_q) begin
          bus_read_d  = 1'b1;
          bus_drive_d = 1'b1;
        end else begin
          bus_wr_n_d  = 1'b0;
        end
      end
      S_ACCESS: begin
        state_d = S_ACK;
        if (!we_q) begin
          if (gnt_b_q) b_rdata_d = BUS;
          else         a_rdata_d = BUS;
        end
        if (gnt_b_q) b_ack_d = 1'b1;
        else         a_ack_d = 1'b1;
      end
      S_ACK: begin
        state_d  = S_IDLE;
        last_b_d = gnt_b_q;
        busy_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge i_CLOCK) begin
    if (i_RESET) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      gnt_b_q     <= 1'b0;
      last_b_q    <= 1'b1;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      bus_read_q  <= 1'b0;
      bus_wr_n_q  <= 1'b1;
      bus_drive_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      gnt_b_q     <= gnt_b_d;
      last_b_q    <= last_b_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      bus_read_q  <= bus_read_d;
      bus_wr_n_q  <= bus_wr_n_d;
      bus_drive_q <= bus_drive_d;
      busy_q      <= busy_d;
    end
  end

  // Reset arriving during a write ACCESS must not let the RAM capture at the
  // reset edge, so the capture strobe and bus driver are masked by i_RESET.
  assign arb_if.o_BUS_READ    = bus_read_q & ~i_RESET;
  assign BUS                  = (bus_drive_q && !i_RESET) ? wdata_q : {DATA_WIDTH{1'bz}};
  assign arb_if.o_BUS_WRITE_n = bus_wr_n_q;
  assign arb_if.o_MAR_DATA    = addr_q;
  assign arb_if.o_BUSY        = busy_q;
  assign arb_if.o_A_ACK       = a_ack_q;
  assign arb_if.o_B_ACK       = b_ack_q;
  assign arb_if.o_A_DATA      = a_rdata_q;
  assign arb_if.o_B_DATA      = b_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural RAM on the shared bus,
// scoreboard of expected acks, per-cycle bus exclusion monitor.
module tb_mem_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;

  typedef struct {
    logic          port_b;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int unsigned   cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          preload = 1'b1;
  wire  [DW-1:0] BUS;
  int unsigned   cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  exp_t          sb_q[$];
  logic [DW-1:0] ram [16];
  logic [DW-1:0] ram_exp [16];
  logic [DW-1:0] mdl_a = '0;
  logic [DW-1:0] mdl_b = '0;
  logic          prev_a_ack = 1'b0;
  logic          prev_b_ack = 1'b0;

  mem_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) arb_if ();

  mem_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .i_CLOCK (clk),
    .i_RESET (rst),
    .arb_if  (arb_if.slave),
    .BUS     (BUS)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: drives the bus while output-enabled, captures on the strobe.
  assign BUS = (!arb_if.o_BUS_WRITE_n) ? ram[arb_if.o_MAR_DATA] : {DW{1'bz}};

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) ram[i] <= 8'(i * 17 + 3);
    end else if (arb_if.o_BUS_READ) begin
      ram[arb_if.o_MAR_DATA] <= BUS;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic take_ack(input logic port_b);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq(port_b ? "b_ack_unexpected" : "a_ack_unexpected", sb_q.size(), 1);
      return;
    end
    e = sb_q.pop_front();
    check_eq("ack_port", {31'd0, port_b}, {31'd0, e.port_b});
    check_eq("ack_cycle", cyc, e.cyc);
    if (port_b) begin
      if (!e.we) mdl_b = e.data;
      check_eq("b_data", arb_if.o_B_DATA, mdl_b);
      check_eq("a_data_hold", arb_if.o_A_DATA, mdl_a);
    end else begin
      if (!e.we) mdl_a = e.data;
      check_eq("a_data", arb_if.o_A_DATA, mdl_a);
      check_eq("b_data_hold", arb_if.o_B_DATA, mdl_b);
    end
  endtask

  // Monitor: bus exclusion every cycle, bus contents against the head of the
  // scoreboard, and ack pulses popped from the scoreboard.
  always @(negedge clk) begin
    check_eq("bus_excl", {31'd0, arb_if.o_BUS_READ & ~arb_if.o_BUS_WRITE_n}, 0);
    if (arb_if.o_BUS_READ && sb_q.size() > 0) begin
      check_eq("wr_we", {31'd0, sb_q[0].we}, 1);
      check_eq("wr_addr", arb_if.o_MAR_DATA, sb_q[0].addr);
      check_eq("wr_bus", BUS, sb_q[0].data);
    end
    if (!arb_if.o_BUS_WRITE_n && sb_q.size() > 0) begin
      check_eq("rd_we", {31'd0, sb_q[0].we}, 0);
      check_eq("rd_addr", arb_if.o_MAR_DATA, sb_q[0].addr);
    end
    if (arb_if.o_A_ACK) begin
      check_eq("a_ack_pulse", {31'd0, prev_a_ack}, 0);
      take_ack(1'b0);
    end
    if (arb_if.o_B_ACK) begin
      check_eq("b_ack_pulse", {31'd0, prev_b_ack}, 0);
      take_ack(1'b1);
    end
    prev_a_ack = arb_if.o_A_ACK;
    prev_b_ack = arb_if.o_B_ACK;
  end

  task automatic drive(input logic port_b, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (port_b) begin
      arb_if.i_B_REQ = req; arb_if.i_B_WE = we; arb_if.i_B_ADDR = addr; arb_if.i_B_DATA = data;
    end else begin
      arb_if.i_A_REQ = req; arb_if.i_A_WE = we; arb_if.i_A_ADDR = addr; arb_if.i_A_DATA = data;
    end
  endtask

  task automatic push_exp(input logic port_b, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input int unsigned ack_cyc);
    exp_t e;
    e.port_b = port_b;
    e.we     = we;
    e.addr   = addr;
    e.data   = we ? data : ram_exp[addr];
    e.cyc    = ack_cyc;
    sb_q.push_back(e);
    if (we) ram_exp[addr] = data;
  endtask

  // One transaction on a single port; request dropped in the ack cycle.
  task automatic do_txn(input logic port_b, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data);
    @(negedge clk);
    push_exp(port_b, we, addr, data, cyc + 3);
    drive(port_b, 1'b1, we, addr, data);
    repeat (3) @(negedge clk);
    drive(port_b, 1'b0, we, addr, data);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    mdl_a = '0;
    mdl_b = '0;
    rst = 1'b0;
  endtask

  int unsigned c0;

  initial begin
    for (int i = 0; i < 16; i++) ram_exp[i] = 8'(i * 17 + 3);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    preload = 1'b0;

    // reset state
    check_eq("rst_busy", {31'd0, arb_if.o_BUSY}, 0);
    check_eq("rst_a_ack", {31'd0, arb_if.o_A_ACK}, 0);
    check_eq("rst_b_ack", {31'd0, arb_if.o_B_ACK}, 0);
    check_eq("rst_bus_read", {31'd0, arb_if.o_BUS_READ}, 0);
    check_eq("rst_bus_wr_n", {31'd0, arb_if.o_BUS_WRITE_n}, 1);
    check_eq("rst_mar", arb_if.o_MAR_DATA, 0);
    check_eq("rst_a_data", arb_if.o_A_DATA, 0);
    check_eq("rst_b_data", arb_if.o_B_DATA, 0);
    rst = 1'b0;
    @(negedge clk);

    // A-only write, then B-only read of the same word
    do_txn(1'b0, 1'b1, 4'd3, 8'h5A);
    check_eq("idle_busy", {31'd0, arb_if.o_BUSY}, 0);
    do_txn(1'b1, 1'b0, 4'd3, 8'h00);

    // simultaneous held requests after reset: A, B, A
    apply_reset();
    @(negedge clk);
    c0 = cyc;
    push_exp(1'b0, 1'b0, 4'd1, 8'h00, c0 + 3);
    push_exp(1'b1, 1'b0, 4'd2, 8'h00, c0 + 7);
    push_exp(1'b0, 1'b0, 4'd1, 8'h00, c0 + 11);
    drive(1'b0, 1'b1, 1'b0, 4'd1, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 4'd2, 8'h00);
    @(negedge clk);
    check_eq("rr_busy", {31'd0, arb_if.o_BUSY}, 1);
    repeat (6) @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 4'd2, 8'h00);
    repeat (4) @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 4'd1, 8'h00);
    repeat (2) @(negedge clk);

    // A changes its request during SETUP of a write to 5
    @(negedge clk);
    push_exp(1'b0, 1'b1, 4'd5, 8'h3C, cyc + 3);
    drive(1'b0, 1'b1, 1'b1, 4'd5, 8'h3C);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 4'd7, 8'hFF);
    repeat (3) @(negedge clk);

    // reset during write ACCESS to 9: no write, no ack
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 4'd9, 8'hEE);
    repeat (2) @(negedge clk);
    check_eq("acc_bus_read", {31'd0, arb_if.o_BUS_READ}, 1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 4'd9, 8'hEE);
    @(negedge clk);
    mdl_a = '0;
    mdl_b = '0;
    check_eq("rsta_busy", {31'd0, arb_if.o_BUSY}, 0);
    check_eq("rsta_bus_read", {31'd0, arb_if.o_BUS_READ}, 0);
    check_eq("rsta_bus_wr_n", {31'd0, arb_if.o_BUS_WRITE_n}, 1);
    check_eq("rsta_a_ack", {31'd0, arb_if.o_A_ACK}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // traffic after the aborted write
    do_txn(1'b0, 1'b0, 4'd5, 8'h00);
    do_txn(1'b1, 1'b0, 4'd9, 8'h00);
    do_txn(1'b1, 1'b1, 4'd0, 8'hC3);
    do_txn(1'b0, 1'b0, 4'd0, 8'h00);
    repeat (3) @(negedge clk);

    check_eq("sb_empty", sb_q.size(), 0);
    check_eq("ram3", ram[3], ram_exp[3]);
    check_eq("ram5", ram[5], ram_exp[5]);
    check_eq("ram7", ram[7], ram_exp[7]);
    check_eq("ram9", ram[9], ram_exp[9]);
    check_eq("ram0", ram[0], ram_exp[0]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of RAM words, BUS and both requester data paths.
REQ-002 Parameter ADDRESS_WIDTH, default 4, width of RAM addresses and the MAR output.
REQ-003 i_CLOCK  input  1  sole clock; all state updates on rising edge.
REQ-004 i_RESET  input  1  synchronous, active-high reset.
REQ-005 i_A_REQ / i_B_REQ  input  1 each  access request from requester A (CPU) / B (loader); level, held until ack.
REQ-006 i_A_WE / i_B_WE  input  1 each  1 = write RAM, 0 = read RAM.
REQ-007 i_A_ADDR / i_B_ADDR  input  ADDRESS_WIDTH each  target address.
REQ-008 i_A_DATA / i_B_DATA  input  DATA_WIDTH each  write data.
REQ-009 o_A_ACK / o_B_ACK  output  1 each  one-cycle completion pulse.
REQ-010 o_A_DATA / o_B_DATA  output  DATA_WIDTH each  read data; valid in the ack cycle, held until that port's next read completes.
REQ-011 BUS  inout  DATA_WIDTH  shared RAM data bus; high-Z unless this block is writing.
REQ-012 o_MAR_DATA  output  ADDRESS_WIDTH  RAM address.
REQ-013 o_BUS_READ  output  1  RAM capture strobe; RAM stores BUS at the rising edge while high.
REQ-014 o_BUS_WRITE_n  output  1  active-low RAM output enable; RAM drives BUS while low.
REQ-015 o_BUSY  output  1  high in every state except IDLE.

Function
REQ-016 FSM states are IDLE, SETUP, ACCESS and ACK, traversed in that order for every transaction.
REQ-017 IDLE: if any request is high, the block latches the winner's WE, ADDR and DATA plus the granted-port id, then moves to SETUP; otherwise it stays in IDLE.
REQ-018 Arbitration: a single request wins; with both high, the port not granted last wins (round-robin); after reset the last-granted pointer = B, so A wins the first tie.
REQ-019 SETUP: o_MAR_DATA = latched address; o_BUS_READ = 0; o_BUS_WRITE_n = 1; BUS high-Z; next state is ACCESS.
REQ-020 ACCESS, read: o_BUS_WRITE_n = 0; BUS not driven by this block; BUS sampled at the closing edge into the granted port's data register.
REQ-021 ACCESS, write: BUS driven with latched data; o_BUS_READ = 1 for exactly this cycle; o_BUS_WRITE_n = 1.
REQ-022 ACCESS always proceeds to ACK; ACK pulses the granted port's ack for one cycle, updates the last-granted pointer, then returns to IDLE.
REQ-023 Latency: request first seen high at edge N (in IDLE) -> ack high in cycle N+3; issue rate is at most one transaction per 4 cycles.
REQ-024 o_MAR_DATA holds the latched address from SETUP through ACK; its value in IDLE is don't-care.
REQ-025 Bus exclusion: BUS driven by this block only in write-ACCESS; o_BUS_WRITE_n never low in the same cycle; o_BUS_READ and o_BUS_WRITE_n = 0 never coincide.
REQ-026 Request changes after grant (deassert, address or data change) do not affect the transaction in flight; it completes and acks normally.
REQ-027 A request still high in the ACK cycle is treated as a new request at the next IDLE evaluation.
REQ-028 A non-granted port's ack is 0 and its data output is unchanged throughout the other port's transaction.
REQ-029 Requests arriving while o_BUSY is high are evaluated only on return to IDLE; none are lost while held.

Reset
REQ-030 On a rising edge with i_RESET high, in any state: state <- IDLE; acks = 0; o_BUS_READ = 0; o_BUS_WRITE_n = 1; BUS high-Z; o_BUSY = 0; last-granted <- B; o_A_DATA = o_B_DATA = 0; o_MAR_DATA = 0.
REQ-031 Reset during write-ACCESS causes no RAM write at that edge (o_BUS_READ is already 0 after reset); the interrupted transaction is dropped and not acked.
REQ-032 Reset has priority over all other inputs in the same cycle.

Verification
REQ-033 A-only write: A_WE=1, A_ADDR=3, A_DATA=0x5A -> o_BUS_READ high for one cycle with MAR=3 and BUS=0x5A; A_ACK pulses at N+3; RAM[3]=0x5A.
REQ-034 B-only read after the above: B_WE=0, B_ADDR=3 -> o_BUS_WRITE_n low for one cycle; B_ACK pulses at N+3 with o_B_DATA=0x5A; o_A_DATA unchanged.
REQ-035 Simultaneous requests held high after reset: A read addr 1, B read addr 2 -> grants alternate A, B, A; acks 4 cycles apart; each data output matches its address.
REQ-036 A drops REQ and changes ADDR to 7 during SETUP of a write to addr 5 -> write lands at addr 5; A_ACK still pulses; RAM[7] untouched.
REQ-037 Reset asserted during write-ACCESS to addr 9 -> next cycle IDLE, strobes inactive, BUS high-Z, no ack; RAM[9] keeps its prior value.
REQ-038 Every test: checker asserts REQ-025 exclusion every cycle and flags any X/contention on BUS.
